// File: rtl/exec_alu_stage.sv
// RV32I execute stage: operand select, single-cycle ALU ops, 1-bit-per-cycle serial shifts,
// registered result on a valid/ready handshake. in_params = {exec_op[3:0], operand1_sel, operand2_sel}.
module exec_alu_stage #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      in_params,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RD_W-1:0] out_rd
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
   localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SK_SLL = 2'd0,
      SK_SRL = 2'd1,
      SK_SRA = 2'd2
   } shift_kind_e;

   state_e            state_q, state_d;
   shift_kind_e       kind_q, kind_d, kind_s;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [SHW-1:0]    cnt_q, cnt_d;

   logic [3:0]        exec_op_s;
   logic [2:0]        funct3_s;
   logic              f7_s;
   logic [XLEN-1:0]   op1_s, op2_s, alu_res_s;
   logic [SHW-1:0]    shamt_s;
   logic              is_shift_s, accept_s;

   function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v, input shift_kind_e k);
      logic [XLEN-1:0] r;
      case (k)
         SK_SLL:  r = {v[XLEN-2:0], 1'b0};
         SK_SRL:  r = {1'b0, v[XLEN-1:1]};
         SK_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign exec_op_s  = in_params[5:2];
   assign funct3_s   = exec_op_s[2:0];
   assign f7_s       = exec_op_s[3];
   assign op1_s      = in_params[1] ? in_pc  : in_rs1;
   assign op2_s      = in_params[0] ? in_imm : in_rs2;
   assign shamt_s    = op2_s[SHW-1:0];
   assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept_s   = in_valid && in_ready && !flush;

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_rd     = rd_q;

   // Single-cycle ALU result; shifts yield op1 here, which is the shamt==0 answer.
   always_comb begin
      alu_res_s = op1_s;
      kind_s    = SK_SLL;
      case (funct3_s)
         3'b000:  alu_res_s = f7_s ? (op1_s - op2_s) : (op1_s + op2_s);
         3'b010:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op1_s) < $signed(op2_s))};
         3'b011:  alu_res_s = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
         3'b100:  alu_res_s = op1_s ^ op2_s;
         3'b110:  alu_res_s = op1_s | op2_s;
         3'b111:  alu_res_s = op1_s & op2_s;
         default: alu_res_s = op1_s;
      endcase
      if (funct3_s == 3'b001) begin
         kind_s = SK_SLL;
      end else begin
         kind_s = f7_s ? SK_SRA : SK_SRL;
      end
   end

   // Next-state and datapath updates; result_q doubles as the shift accumulator.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      result_d = result_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      kind_d   = kind_q;
      if (flush) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               result_d = shift_step(result_q, kind_q);
               cnt_d    = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            ST_IDLE, ST_DONE: begin
               if (accept_s) begin
                  rd_d = in_rd;
                  if (is_shift_s && (shamt_s != CNT_ZERO)) begin
                     result_d = op1_s;
                     cnt_d    = shamt_s;
                     kind_d   = kind_s;
                     state_d  = ST_SHIFT;
                     valid_d  = 1'b0;
                  end else begin
                     result_d = alu_res_s;
                     state_d  = ST_DONE;
                     valid_d  = 1'b1;
                  end
               end else if ((state_q == ST_DONE) && out_ready) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         result_q <= {XLEN{1'b0}};
         rd_q     <= {RD_W{1'b0}};
         cnt_q    <= CNT_ZERO;
         kind_q   <= SK_SLL;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         kind_q   <= kind_d;
      end
   end

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed self-checking bench for exec_alu_stage with hand-computed expected values.
module tb_exec_alu_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [5:0]  in_params;
   logic [31:0] in_rs1, in_rs2, in_pc, in_imm, out_result;
   logic [4:0]  in_rd, out_rd;

   int n_checks = 0;
   int n_fail   = 0;

   exec_alu_stage #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_params(in_params),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic s1, input logic s2,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
      in_params = {op, s1, s2};
      in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm; in_rd = rd;
      in_valid = 1'b1;
   endtask

   // Issue one op with out_ready=1, measure latency, check result/tag, then drain to IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic s1, input logic s2,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      drive(op, s1, s2, rs1, rs2, pc, imm, rd);
      #1;
      check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         check_eq({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
         tick();
         lat++;
      end
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_res"}, out_result, exp_res);
      check_eq({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
      tick();
      check_eq({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_params = 6'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_pc = 32'd0; in_imm = 32'd0; in_rd = 5'd0;
      repeat (2) tick();
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_result", out_result, 32'd0);
      check_eq("rst_rd", {27'd0, out_rd}, 32'd0);
      check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      run_op("add",   4'b0000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 32'd12, 1);
      run_op("sub",   4'b1000, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4, 32'hFFFF_FFFF, 1);
      run_op("slt",   4'b0010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 32'd1, 1);
      run_op("sltu",  4'b0011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6, 32'd0, 1);
      run_op("sra",   4'b1101, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd4, 5'd7, 32'hF800_0000, 5);
      run_op("srl",   4'b0101, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd4, 5'd8, 32'h0800_0000, 5);
      run_op("sll0",  4'b0001, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 5'd9, 32'h8000_0000, 1);
      run_op("sll25", 4'b0001, 1'b0, 1'b1, 32'h0000_0001, 32'd0, 32'd0, 32'h25, 5'd10, 32'h0000_0020, 6);
      run_op("pcimm", 4'b0000, 1'b1, 1'b1, 32'd0, 32'd0, 32'h1000, 32'hFFFF_FFFC, 5'd11, 32'h0000_0FFC, 1);
      run_op("xor",   4'b1100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd12, 32'h0FF0_0FF0, 1);
      run_op("or",    4'b1110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd13, 32'hFFF0_FFF0, 1);
      run_op("and",   4'b1111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd14, 32'hF000_F000, 1);
      run_op("slt_b3", 4'b1010, 1'b0, 1'b0, 32'd3, 32'd2, 32'd0, 32'd0, 5'd15, 32'd0, 1);

      // Backpressure then back-to-back accept.
      out_ready = 1'b0;
      drive(4'b0000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd0, 32'd0, 5'd7);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
         check_eq("bp_result", out_result, 32'd30);
         check_eq("bp_rd", {27'd0, out_rd}, 32'd7);
         check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      drive(4'b0000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd9);
      #1;
      check_eq("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check_eq("b2b_valid", {31'd0, out_valid}, 32'd1);
      check_eq("b2b_result", out_result, 32'd3);
      check_eq("b2b_rd", {27'd0, out_rd}, 32'd9);
      tick();
      check_eq("b2b_drain", {31'd0, out_valid}, 32'd0);

      // Flush during a 20-bit SLL.
      drive(4'b0001, 1'b0, 1'b1, 32'd1, 32'd0, 32'd0, 32'd20, 5'd2);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
      check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      repeat (25) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check_eq("flush_stale", {31'd0, seen}, 32'd0);

      // Reset during a 20-bit SLL.
      drive(4'b0001, 1'b0, 1'b1, 32'd1, 32'd0, 32'd0, 32'd20, 5'd6);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("rmid_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rmid_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rmid_result", out_result, 32'd0);
      check_eq("rmid_rd", {27'd0, out_rd}, 32'd0);
      seen = 1'b0;
      repeat (25) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check_eq("rmid_stale", {31'd0, seen}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Execute stage directly downstream of the exec-unit decoder.
- Consumes the decoded `exec_unit_params` plus register, PC and immediate operands, and selects the ALU operands.
- Computes the RV32I integer result with a 1-bit-per-cycle serial shifter for shift ops.
- Presents the result to the writeback/memory stage over a valid/ready handshake with a registered output.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination-register tag width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous kill of any in-flight op.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op this cycle.
- in_params  input  6  `exec_unit_params`: exec_op[3:0], operand1_sel (REG=0, PC=1), operand2_sel (REG=0, IMM=1).
- in_rs1  input  XLEN  rs1 value.
- in_rs2  input  XLEN  rs2 value.
- in_pc  input  XLEN  instruction PC.
- in_imm  input  XLEN  sign-extended immediate.
- in_rd  input  RD_W  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  XLEN  ALU result.
- out_rd  output  RD_W  destination tag, carried unchanged from in_rd.

Behaviour:
- Reset and interface decisions: one clock, clk; reset rst_n is synchronous, active-low. All state is sampled on the rising clk edge.
- Reset values: state=IDLE, out_valid=0, out_result=0, out_rd=0, shift counter=0. in_ready is combinational and therefore 1 after reset.
- Operand selection:
  - op1 = operand1_sel ? in_pc : in_rs1.
  - op2 = operand2_sel ? in_imm : in_rs2.
- exec_op = {funct7[5], funct3}:
  - 0000 ADD; 1000 SUB.
  - x001 SLL; x010 SLT (signed); x011 SLTU; x100 XOR.
  - 0101 SRL; 1101 SRA.
  - x110 OR; x111 AND.
  - Bit 3 is honoured only for funct3 000 and 101, and ignored otherwise.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1 in bit 0, with upper bits zero.
  - Shift amount is op2[4:0]; upper bits of op2 are ignored.
- States:
  - IDLE: no op held.
  - SHIFT: serial shift in progress.
  - DONE: result held, out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 in SHIFT.
- Accept = in_valid & in_ready & ~flush.
  - Non-shift op, or shift with shamt==0: result computed combinationally and registered; next state DONE. out_valid rises in the cycle after accept (latency 1).
  - Shift with shamt=k>0: accumulator=op1, counter=k; next state SHIFT.
- SHIFT, each cycle:
  - Shift the accumulator 1 bit (SLL: zero fill left; SRL: zero fill right; SRA: replicate the sign bit).
  - Decrement the counter.
  - When counter==1 this cycle, next state is DONE.
  - out_valid therefore rises k+1 cycles after accept.
- DONE: out_result and out_rd are stable while out_valid & ~out_ready.
  - On out_ready & accept in the same cycle: the new op loads back-to-back. The next state is DONE or SHIFT, with no bubble for single-cycle ops.
  - On out_ready with no accept: next state IDLE, out_valid=0.
- flush: highest priority after reset. Next state IDLE, out_valid=0, and any accept in that cycle is dropped. out_result and out_rd keep their values (don't-care).
- Reset asserted mid-SHIFT or mid-DONE: the op is discarded and all reset values apply on the next edge.
- out_valid never deasserts without out_ready, flush or reset.

Test Plan:
- Reset, then ADD: rs1=5, rs2=7, sel REG/REG, exec_op 0000 -> out_valid at cycle+1, out_result=12, out_rd matches in_rd.
- SUB wrap and SLT/SLTU: rs1=0, rs2=1, 1000 -> 0xFFFFFFFF. rs1=0xFFFFFFFF, rs2=1:
  - SLT -> 1.
  - SLTU -> 0.
- Shifts on 0x80000000 with IMM shamt 4:
  - SRA -> 0xF8000000, out_valid exactly 5 cycles after accept; in_ready=0 during SHIFT.
  - SRL -> 0x08000000.
  - SLL with shamt 0 -> 1-cycle latency. imm=0x25 -> shift by 5 only.
- PC/IMM select: pc=0x1000, imm=0xFFFFFFFC, sel PC/IMM, 0000 -> 0x00000FFC.
- Backpressure/throughput: out_ready=0 for 3 cycles -> result and out_rd held stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new ADD accepted the same cycle, out_valid stays 1 with the new result next cycle.
- flush during a 20-bit SLL, and rst_n=0 mid-SHIFT -> IDLE next cycle, out_valid=0, in_ready=1, and no stale result ever emitted.
